// File: rtl/fpu_pkg.sv
// Shared FPU constants and types.
// Used by the significand unpacker and its leading-zero counter.
package fpu_pkg;
  localparam int DBL_FRAC_W = 52;
  localparam int SGL_FRAC_W = 23;
  localparam int SIG_W      = 53;
  localparam int LZ_W       = 6;

  typedef logic [SIG_W-1:0] sig_t;
endpackage

// File: rtl/fp_lzc53.sv
// Tree leading-zero counter; count from the MSB plus an all-zero flag.
// Input is padded with ones below the LSB up to 2**LZ_W leaves.
module fp_lzc53 #(
  parameter int W    = 53,
  parameter int LZ_W = 6
) (
  input  logic [W-1:0]    a,
  output logic [LZ_W-1:0] cnt,
  output logic            zero
);
  localparam int P = 1 << LZ_W;

  logic [P-1:0]    v;
  logic [LZ_W-1:0] c [P];

  // Pairwise reduction in place; node j of a level reads 2j and 2j+1
  always_comb begin
    v = {a, {(P-W){1'b1}}};
    v = {<<{v}};
    for (int j = 0; j < P; j++) c[j] = '0;
    for (int k = 0; k < LZ_W; k++) begin
      for (int j = 0; j < (P >> (k + 1)); j++) begin
        if (v[2*j]) begin
          c[j] = c[2*j];
        end else begin
          c[j] = c[2*j+1] | LZ_W'(1 << k);
        end
        v[j] = v[2*j] | v[2*j+1];
      end
    end
    zero = ~|a;
    cnt  = zero ? '0 : c[0];
  end
endmodule

// File: rtl/fp_unpacker.sv
// Significand unpack stage: fraction extract, hidden bit, LZC, normalize.
// UNPACKER_DENORM_FLUSH_EN flushes denormal significands to zero.
module fp_unpacker
  import fpu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            dbs,
  input  logic [N-1:0]    x,
  input  logic            ez,
  input  logic            normal,
  output logic            out_valid,
  output logic [LZ_W-1:0] lz,
  output logic [SIG_W-1:0] f,
  output logic            fz,
  output logic [DBL_FRAC_W-1:0] h
);
  logic                  out_valid_q, out_valid_d;
  logic [LZ_W-1:0]       lz_q, lz_d;
  sig_t                  f_q, f_d;
  logic                  fz_q, fz_d;
  logic [DBL_FRAC_W-1:0] h_q, h_d;

  logic [DBL_FRAC_W-1:0] h_c;
  sig_t                  s;
  logic [LZ_W-1:0]       lz_c;
  logic                  s_zero;
  logic                  unused_x;

  assign unused_x = ^{x[N-1:55], s_zero};

  assign h_c = dbs ? x[51:0]
                   : {x[32+SGL_FRAC_W-1:32], (DBL_FRAC_W-SGL_FRAC_W)'(0)};
  assign s   = {~ez, h_c};

  fp_lzc53 #(.W(SIG_W), .LZ_W(LZ_W)) u_lzc (
    .a    (s),
    .cnt  (lz_c),
    .zero (s_zero)
  );

  always_comb begin
    out_valid_d = in_valid;
    lz_d        = lz_q;
    f_d         = f_q;
    fz_d        = fz_q;
    h_d         = h_q;
    if (in_valid) begin
      h_d  = h_c;
      fz_d = (h_c == '0);
      lz_d = lz_c;
      f_d  = normal ? (s << lz_c) : s;
`ifdef UNPACKER_DENORM_FLUSH_EN
      if (ez) begin
        f_d  = '0;
        lz_d = '0;
        fz_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      lz_q        <= '0;
      f_q         <= '0;
      fz_q        <= 1'b0;
      h_q         <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      lz_q        <= lz_d;
      f_q         <= f_d;
      fz_q        <= fz_d;
      h_q         <= h_d;
    end
  end

  assign out_valid = out_valid_q;
  assign lz        = lz_q;
  assign f         = f_q;
  assign fz        = fz_q;
  assign h         = h_q;
endmodule

// File: tb/tb_fp_unpacker.sv
// Directed bench for fp_unpacker with hand-computed vectors.
// Honours UNPACKER_DENORM_FLUSH_EN for the denormal expectations.
module tb_fp_unpacker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        dbs;
  logic [63:0] x;
  logic        ez;
  logic        normal;
  logic        out_valid;
  logic [5:0]  lz;
  logic [52:0] f;
  logic        fz;
  logic [51:0] h;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp_unpacker #(.N(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .dbs       (dbs),
    .x         (x),
    .ez        (ez),
    .normal    (normal),
    .out_valid (out_valid),
    .lz        (lz),
    .f         (f),
    .fz        (fz),
    .h         (h)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic d, input logic [63:0] xx,
                       input logic e, input logic n);
    in_valid = v;
    dbs      = d;
    x        = xx;
    ez       = e;
    normal   = n;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov,
                         input logic [5:0] elz, input logic [52:0] ef,
                         input logic efz, input logic [51:0] eh);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
    chk({tag, ".lz"},        64'(lz),        64'(elz));
    chk({tag, ".f"},         64'(f),         64'(ef));
    chk({tag, ".fz"},        64'(fz),        64'(efz));
    chk({tag, ".h"},         64'(h),         64'(eh));
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b1);
    chk_all("reset", 1'b0, 6'd0, 53'h0, 1'b0, 52'h0);

    rst_n = 1'b1;
    drive(1'b1, 1'b1, 64'h3FF0000000000000, 1'b0, 1'b1);
    chk_all("dbl_norm", 1'b1, 6'd0, 53'h10000000000000, 1'b1, 52'h0);

`ifdef UNPACKER_DENORM_FLUSH_EN
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b1);
    chk_all("dbl_den_n1", 1'b1, 6'd0, 53'h0, 1'b1, 52'h8000000000000);
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b0);
    chk_all("dbl_den_n0", 1'b1, 6'd0, 53'h0, 1'b1, 52'h8000000000000);
    drive(1'b1, 1'b1, 64'h0000000000000001, 1'b1, 1'b1);
    chk_all("dbl_deep", 1'b1, 6'd0, 53'h0, 1'b1, 52'h1);
    drive(1'b1, 1'b0, 64'h0000000100000000, 1'b1, 1'b1);
    chk_all("sgl_den", 1'b1, 6'd0, 53'h0, 1'b1, 52'h0000020000000);
`else
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b1);
    chk_all("dbl_den_n1", 1'b1, 6'd1, 53'h10000000000000, 1'b0,
            52'h8000000000000);
    drive(1'b1, 1'b1, 64'h0008000000000000, 1'b1, 1'b0);
    chk_all("dbl_den_n0", 1'b1, 6'd1, 53'h08000000000000, 1'b0,
            52'h8000000000000);
    drive(1'b1, 1'b1, 64'h0000000000000001, 1'b1, 1'b1);
    chk_all("dbl_deep", 1'b1, 6'd52, 53'h10000000000000, 1'b0, 52'h1);
    drive(1'b1, 1'b0, 64'h0000000100000000, 1'b1, 1'b1);
    chk_all("sgl_den", 1'b1, 6'd23, 53'h10000000000000, 1'b0,
            52'h0000020000000);
`endif

    drive(1'b1, 1'b0, 64'h3FC00000DEADBEEF, 1'b0, 1'b1);
    chk_all("sgl_norm", 1'b1, 6'd0, 53'h18000000000000, 1'b0,
            52'h8000000000000);

    drive(1'b1, 1'b1, 64'h4000000000000000, 1'b0, 1'b0);
    chk_all("dbl_norm_n0", 1'b1, 6'd0, 53'h10000000000000, 1'b1, 52'h0);

    drive(1'b1, 1'b1, 64'h0, 1'b1, 1'b1);
    chk_all("zero", 1'b1, 6'd0, 53'h0, 1'b1, 52'h0);

    drive(1'b1, 1'b1, 64'h000123456789ABCD, 1'b0, 1'b1);
    chk_all("dbl_mix", 1'b1, 6'd0, 53'h1123456789ABCD, 1'b0,
            52'h123456789ABCD);

    drive(1'b0, 1'b1, 64'h0000000000000001, 1'b1, 1'b1);
    chk_all("hold1", 1'b0, 6'd0, 53'h1123456789ABCD, 1'b0,
            52'h123456789ABCD);
    drive(1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0);
    chk_all("hold2", 1'b0, 6'd0, 53'h1123456789ABCD, 1'b0,
            52'h123456789ABCD);

    rst_n = 1'b0;
    drive(1'b1, 1'b1, 64'h3FF0000000000000, 1'b0, 1'b1);
    chk_all("reset2", 1'b0, 6'd0, 53'h0, 1'b0, 52'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
